// File: rtl/multiplicador_fd.sv
// multiplicador_fd: datapath of an N-bit unsigned shift-and-add multiplier.
// Holds the multiplicand (b), the accumulator with carry (c:a), the multiplier /
// low product (q) and an iteration counter. A separate control unit drives the
// enable/load strobes and watches qlsb and zero. The product is {a,q}.
module multiplicador_fd #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_rst,
  input  logic             a_en,
  input  logic             b_en,
  input  logic             q_en,
  input  logic             cnt_en,
  input  logic             a_ld,
  input  logic             b_ld,
  input  logic             q_ld,
  input  logic             cnt_ld,
  output logic             qlsb,
  output logic             zero,
  input  logic [N-1:0]     B_in,
  input  logic [N-1:0]     Q_in,
  output logic [2*N-1:0]   P_out
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          c;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;

  // The add is N+1 bits wide so the carry out of A+B lands in c; the old c is
  // discarded because the accumulator is only ever added into right after a
  // shift, which has already cleared c.
  logic [N:0] sum;
  logic [N:0] shifted;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign shifted = {1'b0, c, a[N-1:1]};

  // Multiplicand register: loads only on an explicit enabled load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b <= '0;
    end else if (b_en && b_ld) begin
      b <= B_in;
    end
  end

  // Accumulator with carry: synchronous clear beats add, add or right shift when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {c, a} <= '0;
    end else if (a_rst) begin
      {c, a} <= '0;
    end else if (a_en) begin
      if (a_ld) begin
        {c, a} <= sum;
      end else begin
        {c, a} <= shifted;
      end
    end
  end

  // Multiplier register: load operand, or shift right pulling in the pre-edge a[0]
  // so that c:a:q behaves as one long shift register during a shift cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (q_en) begin
      if (q_ld) begin
        q <= Q_in;
      end else begin
        q <= {a[0], q[N-1:1]};
      end
    end
  end

  // Iteration counter: load N, or count down and stick at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt_en) begin
      if (cnt_ld) begin
        cnt <= CNT_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  assign qlsb  = q[0];
  assign zero  = (cnt == '0);
  assign P_out = {a, q};

endmodule

// File: tb/tb_multiplicador_fd.sv
// tb_multiplicador_fd: directed bench for the multiplier datapath. A behavioural
// model tracks the register contents as plain integers and a compare process
// checks the outputs every falling edge; literal checks pin the model.
module tb_multiplicador_fd;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           a_rst, a_en, b_en, q_en, cnt_en;
  logic           a_ld, b_ld, q_ld, cnt_ld;
  logic           qlsb, zero;
  logic [N-1:0]   B_in, Q_in;
  logic [2*N-1:0] P_out;

  int vec_count  = 0;
  int miscompares = 0;

  // model state: accumulator including carry, multiplicand, multiplier, counter
  int m_ca = 0;
  int m_b  = 0;
  int m_q  = 0;
  int m_cnt = 0;
  int n_ca, n_b, n_q, n_cnt;

  multiplicador_fd #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_rst  (a_rst),
    .a_en   (a_en),
    .b_en   (b_en),
    .q_en   (q_en),
    .cnt_en (cnt_en),
    .a_ld   (a_ld),
    .b_ld   (b_ld),
    .q_ld   (q_ld),
    .cnt_ld (cnt_ld),
    .qlsb   (qlsb),
    .zero   (zero),
    .B_in   (B_in),
    .Q_in   (Q_in),
    .P_out  (P_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: arithmetic view of each register's next value.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ca = 0; m_b = 0; m_q = 0; m_cnt = 0;
    end else begin
      n_ca = m_ca; n_b = m_b; n_q = m_q; n_cnt = m_cnt;
      if (b_en && b_ld) n_b = int'(B_in);
      if (a_rst) n_ca = 0;
      else if (a_en) n_ca = a_ld ? (m_ca % (1 << N)) + m_b : m_ca / 2;
      if (q_en) n_q = q_ld ? int'(Q_in) : (m_q / 2) + (m_ca % 2) * (1 << (N - 1));
      if (cnt_en) n_cnt = cnt_ld ? N : ((m_cnt > 0) ? m_cnt - 1 : 0);
      m_ca = n_ca; m_b = n_b; m_q = n_q; m_cnt = n_cnt;
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("P_out", int'(P_out), (m_ca % (1 << N)) * (1 << N) + m_q);
    checkOutput("qlsb", int'(qlsb), m_q % 2);
    checkOutput("zero", int'(zero), (m_cnt == 0) ? 1 : 0);
  end

  task automatic applyStimulus(input logic ar, input logic ae, input logic al,
                               input logic be, input logic bl,
                               input logic qe, input logic ql,
                               input logic ce, input logic cl,
                               input logic [N-1:0] bi, input logic [N-1:0] qi);
    a_rst = ar; a_en = ae; a_ld = al;
    b_en = be; b_ld = bl;
    q_en = qe; q_ld = ql;
    cnt_en = ce; cnt_ld = cl;
    B_in = bi; Q_in = qi;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  // Full control sequence driven from the status flags.
  task automatic runMultiply(input logic [N-1:0] bi, input logic [N-1:0] qi,
                             output int shifts, output int adds);
    int iter;
    shifts = 0;
    adds = 0;
    iter = 0;
    applyStimulus(1, 0, 0, 1, 1, 1, 1, 1, 1, bi, qi);
    while (!zero && iter < 2 * N) begin
      if (qlsb) begin
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, '0, '0);
        adds++;
      end
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 1, 0, '0, '0);
      shifts++;
      iter++;
    end
    if (!zero) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL zero_timeout: zero=%0d after %0d iterations, expected 1", zero, iter);
    end
  endtask

  int shifts, adds;
  int exp_zero [7] = '{0, 0, 0, 0, 1, 1, 1};

  initial begin
    rst = 1'b1;
    a_rst = 0; a_en = 0; a_ld = 0; b_en = 0; b_ld = 0;
    q_en = 0; q_ld = 0; cnt_en = 0; cnt_ld = 0;
    B_in = '0; Q_in = '0;
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_P_out", int'(P_out), 0);
    checkOutput("reset_zero", int'(zero), 1);
    checkOutput("reset_qlsb", int'(qlsb), 0);
    #10 rst = 1'b1;
    idle();

    // 5 x 3
    runMultiply(4'd5, 4'd3, shifts, adds);
    checkOutput("mul5x3_P_out", int'(P_out), 15);
    checkOutput("mul5x3_shifts", shifts, 4);
    checkOutput("mul5x3_adds", adds, 2);

    // 15 x 15, exercises carry out of the add
    runMultiply(4'd15, 4'd15, shifts, adds);
    checkOutput("mul15x15_P_out", int'(P_out), 225);
    checkOutput("mul15x15_adds", adds, 4);

    // 9 x 0, no add cycles at all
    runMultiply(4'd9, 4'd0, shifts, adds);
    checkOutput("mul9x0_P_out", int'(P_out), 0);
    checkOutput("mul9x0_adds", adds, 0);

    // 13 x 11 = 143
    runMultiply(4'd13, 4'd11, shifts, adds);
    checkOutput("mul13x11_P_out", int'(P_out), 143);

    // counter load then six decrements, saturating at zero
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, '0, '0);
    checkOutput("cnt_load_zero", int'(zero), exp_zero[0]);
    for (int i = 1; i < 7; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, '0, '0);
      checkOutput($sformatf("cnt_dec%0d_zero", i), int'(zero), exp_zero[i]);
    end

    // clear beats add; B and Q untouched
    applyStimulus(1, 0, 0, 1, 1, 1, 1, 0, 0, 4'd6, 4'd10);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, '0, '0);
    checkOutput("a6_P_out", int'(P_out), 8'h6A);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0, 4'd3, 4'd0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, '0, '0);
    checkOutput("clear_wins_P_out", int'(P_out), 8'h0A);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, '0, '0);
    checkOutput("b_kept_P_out", int'(P_out), 8'h3A);

    // b_en without b_ld holds B
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd15, 4'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, '0, '0);
    checkOutput("b_hold_P_out", int'(P_out), 8'h3A);

    // asynchronous reset in the middle of a computation
    applyStimulus(1, 0, 0, 1, 1, 1, 1, 1, 1, 4'd15, 4'd15);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, '0, '0);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 1, 0, '0, '0);
    checkOutput("midrun_nonzero", (P_out != '0) ? 1 : 0, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_P_out", int'(P_out), 0);
    checkOutput("async_zero", int'(zero), 1);
    checkOutput("async_qlsb", int'(qlsb), 0);
    idle();
    #3 rst = 1'b1;
    idle();

    // after abort, a fresh multiply works from scratch
    runMultiply(4'd7, 4'd6, shifts, adds);
    checkOutput("mul7x6_P_out", int'(P_out), 42);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
